pipe_flow_ctrl: RTL and testbench

// Parametrised stall/flush/halt sequencer for an in-order N-stage pipeline.

---
 rtl/pipe_flow_ctrl_if.sv | 28 ++
 rtl/pipe_flow_ctrl.sv | 139 +++++++++++++
 tb/tb_pipe_flow_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_flow_ctrl_if.sv
// Handshake bundle between the pipeline datapath and its flow controller.
// The datapath side (master) reports stall/hazard/branch/halt events and
// consumes per-register enables, bubbles, valid bits and the halt flag.
interface pipe_flow_ctrl_if #(
    parameter int NUM_STAGES    = 5,
    parameter int NUM_STALL_SRC = 2,
    parameter int CNT_W         = 16
);
    logic [NUM_STALL_SRC-1:0] stall_req;
    logic                     hazard_stall;
    logic                     br_taken;
    logic                     hlt_decoded;
    logic [NUM_STAGES-1:0]    stage_en;
    logic [NUM_STAGES-1:0]    stage_bubble;
    logic [NUM_STAGES-1:0]    pipe_valid;
    logic                     hlt;
    logic [CNT_W-1:0]         stall_cycles;

    modport master (
        output stall_req, hazard_stall, br_taken, hlt_decoded,
        input  stage_en, stage_bubble, pipe_valid, hlt, stall_cycles
    );

    modport slave (
        input  stall_req, hazard_stall, br_taken, hlt_decoded,
        output stage_en, stage_bubble, pipe_valid, hlt, stall_cycles
    );
endinterface

// File: rtl/pipe_flow_ctrl.sv
// Stall/flush/halt sequencer for an in-order pipeline of NUM_STAGES registers.
// Register 0 is the PC, register NUM_STAGES-1 is MEM/WB. Enables and bubbles
// are combinational from the current state and requests; valid bits and the
// halt tag ride along with the instructions and are updated on each enable.
module pipe_flow_ctrl #(
    parameter int NUM_STAGES    = 5,
    parameter int NUM_STALL_SRC = 2,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_flow_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [NUM_STAGES-1:0] ALL_ON = '1;
    localparam logic [NUM_STAGES-1:0] PC_OFF = {{(NUM_STAGES-1){1'b1}}, 1'b0};
    localparam logic [NUM_STAGES-1:0] HAZ_EN = {{(NUM_STAGES-2){1'b1}}, 2'b00};
    localparam logic [NUM_STAGES-1:0] BUB_1  = NUM_STAGES'(2);
    localparam logic [NUM_STAGES-1:0] BUB_2  = NUM_STAGES'(4);

    state_t                   state_q, state_d;
    logic [NUM_STAGES-1:1]    valid_q;
    logic [NUM_STAGES-1:2]    tag_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [NUM_STALL_SRC-1:0] stall_req_w;
    logic                     stall_any;
    logic [NUM_STAGES-1:0]    en_d, bub_d;
    logic [NUM_STAGES-1:0]    valid_w;
    logic                     tag_ins;
    logic                     cnt_inc;

    // Saturating increment: the counter parks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign stall_req_w = bus.stall_req;
    assign stall_any   = |stall_req_w;
    assign valid_w     = {valid_q, 1'b1};

    // Priority resolution of memory stall, hazard, flush and halt drain.
    always_comb begin
        en_d    = '0;
        bub_d   = '0;
        state_d = state_q;
        tag_ins = 1'b0;
        cnt_inc = 1'b0;
        if (rst_n) begin
            case (state_q)
                RUN: begin
                    if (stall_any) begin
                        cnt_inc = 1'b1;
                    end else if (bus.hazard_stall) begin
                        // Hold PC and IF/ID, inject a NOP into ID/EX.
                        en_d    = HAZ_EN;
                        bub_d   = BUB_2;
                        cnt_inc = 1'b1;
                    end else if (bus.br_taken) begin
                        en_d  = ALL_ON;
                        bub_d = BUB_1;
                    end else if (bus.hlt_decoded) begin
                        // HLT moves on with its tag; nothing new is fetched.
                        en_d    = PC_OFF;
                        bub_d   = BUB_1;
                        tag_ins = 1'b1;
                        state_d = DRAIN;
                    end else begin
                        en_d = ALL_ON;
                    end
                end
                DRAIN: begin
                    if (stall_any) begin
                        cnt_inc = 1'b1;
                    end else begin
                        en_d  = PC_OFF;
                        bub_d = BUB_1;
                        // HLT retires out of writeback on this edge.
                        if (tag_q[NUM_STAGES-1]) begin
                            state_d = HALTED;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State register; HALTED is left only through reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Valid bits and halt tag follow the instructions through enabled registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            tag_q   <= '0;
        end else begin
            for (int i = 1; i < NUM_STAGES; i++) begin
                if (en_d[i]) begin
                    valid_q[i] <= bub_d[i] ? 1'b0 : valid_w[i-1];
                end
            end
            // IF/ID never carries a tag, so ID/EX only gets one on insertion.
            if (en_d[2]) begin
                tag_q[2] <= tag_ins;
            end
            for (int i = 3; i < NUM_STAGES; i++) begin
                if (en_d[i]) begin
                    tag_q[i] <= bub_d[i] ? 1'b0 : tag_q[i-1];
                end
            end
        end
    end

    // Stall-cycle statistics counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_inc) begin
            cnt_q <= sat_inc(cnt_q);
        end
    end

    assign bus.stage_en     = en_d;
    assign bus.stage_bubble = bub_d;
    assign bus.pipe_valid   = valid_w;
    assign bus.hlt          = (state_q == HALTED);
    assign bus.stall_cycles = cnt_q;
endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Bench for pipe_flow_ctrl (5 stages, 2 stall sources, 4-bit counter).
// A model tracks instruction identities per register and derives the
// expected enables, bubbles, valid bits, halt and counter every cycle;
// directed steps add literal expectations on top.
module tb_pipe_flow_ctrl;
    localparam int N  = 5;
    localparam int NS = 2;
    localparam int CW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pipe_flow_ctrl_if #(.NUM_STAGES(N), .NUM_STALL_SRC(NS), .CNT_W(CW)) bus ();

    pipe_flow_ctrl #(.NUM_STAGES(N), .NUM_STALL_SRC(NS), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input logic [NS-1:0] s, input logic h, input logic b, input logic d);
        bus.stall_req    = s;
        bus.hazard_stall = h;
        bus.br_taken     = b;
        bus.hlt_decoded  = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: slot[i] is the id of the instruction held in register i (0 = bubble).
    int   slot [N];
    int   pc, halt_id, mode;   // mode 0 running, 1 draining, 2 halted
    logic m_hlt;
    int   m_cnt;
    logic [N-1:0] e_en, e_bub, e_val;
    logic acc, busy;

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) slot[i] = 0;
            pc = 1; slot[0] = pc; halt_id = 0; mode = 0; m_hlt = 1'b0; m_cnt = 0;
        end
        e_en = '0; e_bub = '0; acc = 1'b0;
        busy = |bus.stall_req;
        if (rst_n && mode != 2 && !busy) begin
            if (mode == 1) begin
                e_en = '1; e_en[0] = 1'b0; e_bub[1] = 1'b1;
            end else if (bus.hazard_stall) begin
                e_en = '1; e_en[1:0] = 2'b00; e_bub[2] = 1'b1;
            end else if (bus.br_taken) begin
                e_en = '1; e_bub[1] = 1'b1;
            end else if (bus.hlt_decoded) begin
                e_en = '1; e_en[0] = 1'b0; e_bub[1] = 1'b1; acc = 1'b1;
            end else begin
                e_en = '1;
            end
        end
        e_val[0] = 1'b1;
        for (int i = 1; i < N; i++) e_val[i] = (slot[i] != 0);

        check("cyc_en",    32'(bus.stage_en),     32'(e_en));
        check("cyc_bub",   32'(bus.stage_bubble), 32'(e_bub));
        check("cyc_valid", 32'(bus.pipe_valid),   32'(e_val));
        check("cyc_hlt",   32'(bus.hlt),          32'(m_hlt));
        check("cyc_cnt",   32'(bus.stall_cycles), 32'(m_cnt));

        if (rst_n) begin
            if (mode != 2 && (busy || (mode == 0 && bus.hazard_stall)))
                m_cnt = (m_cnt < 2**CW - 1) ? m_cnt + 1 : m_cnt;
            if (mode == 1 && e_en[N-1] && slot[N-1] == halt_id) begin
                m_hlt = 1'b1; mode = 2;
            end
            if (acc) begin
                halt_id = slot[1]; mode = 1;
            end
            for (int i = N-1; i >= 1; i--)
                if (e_en[i]) slot[i] = e_bub[i] ? 0 : slot[i-1];
            if (e_en[0]) begin
                pc++; slot[0] = pc;
            end
        end
    end

    task automatic reset_and_fill();
        rst_n = 1'b0;
        drive(2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [N-1:0] fill [4];

    initial begin
        fill = '{5'h03, 5'h07, 5'h0f, 5'h1f};
        drive(2'b00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_en",    32'(bus.stage_en),     32'h0);
        check("rst_bub",   32'(bus.stage_bubble), 32'h0);
        check("rst_valid", 32'(bus.pipe_valid),   32'h01);
        check("rst_hlt",   32'(bus.hlt),          32'h0);
        check("rst_cnt",   32'(bus.stall_cycles), 32'h0);

        // T1: fill after reset release
        rst_n = 1'b1;
        #1;
        check("t1_en", 32'(bus.stage_en), 32'h1f);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t1_fill", 32'(bus.pipe_valid), 32'(fill[k]));
        end

        // T2: single hazard cycle
        drive(2'b00, 1'b1, 1'b0, 1'b0);
        #1;
        check("t2_en",  32'(bus.stage_en),     32'h1c);
        check("t2_bub", 32'(bus.stage_bubble), 32'h04);
        tick();
        drive(2'b00, 1'b0, 1'b0, 1'b0);
        check("t2_valid", 32'(bus.pipe_valid),   32'h1b);
        check("t2_cnt",   32'(bus.stall_cycles), 32'h1);
        repeat (3) tick();

        // T3: hazard beats branch, then branch alone flushes IF/ID
        drive(2'b00, 1'b1, 1'b1, 1'b0);
        #1;
        check("t3_hz_en",  32'(bus.stage_en),     32'h1c);
        check("t3_hz_bub", 32'(bus.stage_bubble), 32'h04);
        tick();
        drive(2'b00, 1'b0, 1'b1, 1'b0);
        #1;
        check("t3_br_en",  32'(bus.stage_en),     32'h1f);
        check("t3_br_bub", 32'(bus.stage_bubble), 32'h02);
        tick();
        drive(2'b00, 1'b0, 1'b0, 1'b0);
        check("t3_valid", 32'(bus.pipe_valid),   32'h15);
        check("t3_cnt",   32'(bus.stall_cycles), 32'h2);

        // T4: halt without stalls
        reset_and_fill();
        drive(2'b00, 1'b0, 1'b0, 1'b1);
        #1;
        check("t4_acc_en",  32'(bus.stage_en),     32'h1e);
        check("t4_acc_bub", 32'(bus.stage_bubble), 32'h02);
        tick();                                   // edge t
        drive(2'b00, 1'b0, 1'b0, 1'b0);
        #1;
        check("t4_drain_en", 32'(bus.stage_en), 32'h1e);
        tick();                                   // t+1
        tick();                                   // t+2
        check("t4_hlt_early", 32'(bus.hlt), 32'h0);
        tick();                                   // t+3
        check("t4_hlt", 32'(bus.hlt), 32'h1);
        drive(2'b11, 1'b1, 1'b1, 1'b1);
        #1;
        check("t4_halt_en",  32'(bus.stage_en),     32'h0);
        check("t4_halt_bub", 32'(bus.stage_bubble), 32'h0);
        tick();
        drive(2'b00, 1'b0, 1'b0, 1'b0);
        check("t4_sticky", 32'(bus.hlt),          32'h1);
        check("t4_cnt",    32'(bus.stall_cycles), 32'h0);

        // T5: two stall cycles during drain delay hlt by two
        reset_and_fill();
        drive(2'b00, 1'b0, 1'b0, 1'b1);
        tick();                                   // t
        drive(2'b10, 1'b0, 1'b0, 1'b0);
        tick();                                   // t+1
        tick();                                   // t+2
        drive(2'b00, 1'b0, 1'b0, 1'b0);
        tick();                                   // t+3
        tick();                                   // t+4
        check("t5_hlt_early", 32'(bus.hlt), 32'h0);
        tick();                                   // t+5
        check("t5_hlt", 32'(bus.hlt),          32'h1);
        check("t5_cnt", 32'(bus.stall_cycles), 32'h2);

        // T6: counter saturation, then reset in the middle of a drain
        reset_and_fill();
        drive(2'b01, 1'b0, 1'b0, 1'b0);
        repeat (20) tick();
        check("t6_sat", 32'(bus.stall_cycles), 32'hf);
        drive(2'b00, 1'b0, 1'b0, 1'b1);
        tick();
        drive(2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        check("t6_drain_hlt", 32'(bus.hlt), 32'h0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_en",    32'(bus.stage_en),     32'h0);
        check("t6_rst_hlt",   32'(bus.hlt),          32'h0);
        check("t6_rst_valid", 32'(bus.pipe_valid),   32'h01);
        check("t6_rst_cnt",   32'(bus.stall_cycles), 32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        check("t6_run_en", 32'(bus.stage_en), 32'h1f);
        repeat (6) tick();
        check("t6_no_hlt", 32'(bus.hlt), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
